// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared constants and the response record for the Booth
//               multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

   // Default operand width and multiplier latency for booth_mul_sched
   localparam int c_default_width   = 11;
   localparam int c_default_mul_lat = 2;

   // Widest operand the response record can carry; the product field is
   // sized for it so one record type serves every WIDTH up to this value.
   localparam int c_max_width       = 32;

   typedef struct packed {
      logic                       id;
      logic [2*c_max_width-1:0]   p;
   } resp_t;

endpackage
`default_nettype wire

// File: rtl/booth_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : booth_resp_fifo
// Description : Response buffer for booth_mul_sched. Power-of-two depth,
//               simultaneous push/pop allowed, head shown combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_resp_fifo
   import booth_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  resp_t                    i_data,
   input  logic                     i_pop,
   output logic                     o_valid,
   output resp_t                    o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_ptr_w = $clog2(DEPTH);

   resp_t                 r_mem [DEPTH];
   logic [c_ptr_w-1:0]    r_wr;
   logic [c_ptr_w-1:0]    r_rd;
   logic [c_ptr_w:0]      r_count;
   logic                  w_pop;

   // A pop request against an empty buffer is ignored
   assign w_pop = i_pop && (r_count != '0);

   // Storage write; contents are only observed through the gated head
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wr <= r_wr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + c_ptr_w'(1);
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
            2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != '0);
   assign o_head  = o_valid ? r_mem[r_rd] : '0;
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/booth_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_sched
// Description : Two-requester issue scheduler for a fixed-latency Booth/Dadda
//               multiplier. Credit-based flow control guarantees that every
//               issued operation has a slot in the response FIFO.
//               Define BOOTH_SCHED_RR_EN for round-robin arbitration;
//               otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_sched
   import booth_pkg::*;
#(
   parameter int WIDTH      = c_default_width,
   parameter int MUL_LAT    = c_default_mul_lat,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   input  logic [2*WIDTH-1:0]   mul_p,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_id,
   output logic [2*WIDTH-1:0]   resp_p
);

   localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
   localparam int c_sum_w = $clog2(FIFO_DEPTH + MUL_LAT + 2) + 1;

   logic                  w_prefer0;
   logic                  w_grant1;
   logic                  w_credit;
   logic                  w_accept;
   logic [c_sum_w-1:0]    w_inflight;
   logic [c_cnt_w-1:0]    w_fifo_count;
   logic                  r_mul_start;
   logic [WIDTH-1:0]      r_mul_a;
   logic [WIDTH-1:0]      r_mul_b;
   logic [MUL_LAT:0]      r_trk_v;
   logic [MUL_LAT:0]      r_trk_id;
   resp_t                 w_push_data;
   resp_t                 w_head;
   logic                  w_fifo_valid;

`ifdef BOOTH_SCHED_RR_EN
   // r_last_id is the last accepted requester; reset to 1 so requester 0 wins first
   logic r_last_id;

   // Round-robin pointer moves only on an accepted handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_id <= 1'b1;
      end else if (w_accept) begin
         r_last_id <= w_grant1;
      end
   end

   assign w_prefer0 = r_last_id;
`else
   assign w_prefer0 = 1'b1;
`endif

   // Count operations currently travelling through the multiplier
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i <= MUL_LAT; i++) begin
         w_inflight = w_inflight + c_sum_w'(r_trk_v[i]);
      end
   end

   // Every in-flight op already owns a FIFO slot, so the FIFO can never overflow
   assign w_credit = (w_inflight + c_sum_w'(w_fifo_count)) < c_sum_w'(FIFO_DEPTH);

   assign w_grant1   = req1_valid && !(req0_valid && w_prefer0);
   assign req0_ready = !rst && w_credit && req0_valid && !w_grant1;
   assign req1_ready = !rst && w_credit && w_grant1;
   assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // Capture the winning operands and pulse the issue strobe for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul_start <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
      end else begin
         r_mul_start <= w_accept;
         if (w_accept) begin
            r_mul_a <= w_grant1 ? req1_a : req0_a;
            r_mul_b <= w_grant1 ? req1_b : req0_b;
         end
      end
   end

   // Tracker stage k holds the op accepted k edges ago; the last stage lines up with mul_p
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_trk_v  <= '0;
         r_trk_id <= '0;
      end else begin
         r_trk_v  <= {r_trk_v[MUL_LAT-1:0], w_accept};
         r_trk_id <= {r_trk_id[MUL_LAT-1:0], w_grant1};
      end
   end

   // Build the FIFO record from the tracker id and the raw product
   always_comb begin
      w_push_data                  = '0;
      w_push_data.id               = r_trk_id[MUL_LAT];
      w_push_data.p[2*WIDTH-1:0]   = mul_p;
   end

   booth_resp_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_trk_v[MUL_LAT]),
      .i_data  (w_push_data),
      .i_pop   (resp_valid && resp_ready),
      .o_valid (w_fifo_valid),
      .o_head  (w_head),
      .o_count (w_fifo_count)
   );

   // Product bits above 2*WIDTH are always zero in the record
   generate
      if (WIDTH < c_max_width) begin : g_unused_hi
         logic w_unused_hi;
         assign w_unused_hi = ^w_head.p[2*c_max_width-1:2*WIDTH];
      end
   endgenerate

   assign mul_start  = r_mul_start;
   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;
   assign resp_valid = w_fifo_valid;
   assign resp_id    = w_head.id;
   assign resp_p     = w_head.p[2*WIDTH-1:0];

endmodule
`default_nettype wire

// File: doc/booth_mul_sched.md
BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 11, operand width in bits.
REQ-002 SHALL have parameter MUL_LAT, default 2, fixed multiplier latency in cycles, range 1..8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, response FIFO entries, power of two, range 2..16.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  requester operand pair valid.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  requester accept.
REQ-008 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  signed operands.
REQ-009 SHALL have port mul_start  output  1  one-cycle issue strobe to the Booth/Dadda multiplier.
REQ-010 SHALL have ports mul_a, mul_b  output  WIDTH  registered operands to the multiplier.
REQ-011 SHALL have port mul_p  input  2*WIDTH  multiplier product.
REQ-012 SHALL have ports resp_valid  output  1, resp_ready  input  1  response handshake.
REQ-013 SHALL have ports resp_id  output  1 (originating requester) and resp_p  output  2*WIDTH (product).

Function
REQ-014 SHALL accept a request when reqN_valid && reqN_ready at a rising edge (accept edge E0).
REQ-015 SHALL assert reqN_ready only for the granted requester and only when inflight + fifo_count < FIFO_DEPTH (credit rule).
REQ-016 SHALL grant exactly one requester per cycle; a lone valid requester is granted.
REQ-017 SHALL register mul_a/mul_b at E0 and drive mul_start high for exactly the cycle after E0; mul_a/mul_b hold their values otherwise.
REQ-018 SHALL track in-flight operations with a MUL_LAT+1 deep valid/id shift register and sample mul_p at edge E0+1+MUL_LAT.
REQ-019 SHALL push {id, mul_p} into the response FIFO at the sampling edge; resp_valid is high in the following cycle when the FIFO was empty.
REQ-020 SHALL present the FIFO head on resp_id/resp_p while resp_valid is high and pop on resp_valid && resp_ready.
REQ-021 SHALL sustain one issue per cycle while credits last; results leave in issue order.
REQ-022 SHALL allow simultaneous push and pop, including when the FIFO is full; fifo_count is unchanged.
REQ-023 SHALL, by the credit rule, never push into a full FIFO; overflow is impossible by construction.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-025 SHALL pass mul_p through unmodified; product arithmetic and sign handling belong to the multiplier.

Reset
REQ-026 SHALL, on rst, clear immediately: req0_ready, req1_ready, mul_start, resp_valid, resp_id = 0; mul_a, mul_b, resp_p = 0; FIFO, pointers and in-flight tracker = empty; priority pointer = 1 (requester 0 wins first).
REQ-027 SHALL discard operations in flight when rst asserts mid-operation; no response for them appears after release.

Configuration
REQ-028 SHALL, with BOOTH_SCHED_RR_EN defined, arbitrate round-robin: on contention, the requester not last accepted wins; the pointer updates only on an accepted handshake.
REQ-029 SHALL, without BOOTH_SCHED_RR_EN, use fixed priority with requester 0 always winning contention; all other behaviour is identical.

Structure
REQ-030 SHALL place the default WIDTH and MUL_LAT constants and a resp_t struct {id, p} in shared package booth_pkg.
REQ-031 SHALL implement the response buffer as sub-module booth_resp_fifo (parameterised depth, count output); arbitration and the tracker stay in booth_mul_sched.

Verification
REQ-032 Bench SHALL model the multiplier behaviourally as a signed multiply delayed by MUL_LAT cycles.
REQ-033 Case: req0 a=3, b=-5 alone, resp_ready=1 -> mul_start 1 cycle after E0; resp_valid after edge E0+MUL_LAT+1; resp_id=0, resp_p=-15.
REQ-034 Case: both valid for 4 cycles, RR_EN defined -> accept order 0,1,0,1. Without RR_EN -> order 0,0,0,0, and req1 waits.
REQ-035 Case: resp_ready=0 with continuous requests, FIFO_DEPTH=4 -> exactly 4 accepts, ready then low. One pop -> exactly one further accept.
REQ-036 Case: FIFO full, pop and push on the same edge -> count stays 4; order and values preserved.
REQ-037 Case: rst pulsed with 2 operations in flight -> all outputs 0 immediately; no resp_valid for the next MUL_LAT+3 cycles; the next request gets a correct response.
REQ-038 Case: operands -1024 x -1024 (WIDTH=11) -> resp_p = 1048576, with no truncation across 22 bits.
